// File: rtl/conv2d_frame_sequencer_if.sv
// rtl/conv2d_frame_sequencer_if.sv - handshake bundle between the frame sequencer and its neighbours
//
// Groups the control, upstream pixel FIFO, padded stream and filter-bank
// valid signals of conv2d_frame_sequencer.
//   master : the sequencer side (drives busy/done/src_rdreq/pad_data/pad_empty)
//   slave  : the environment side (drives start/src_data/src_empty/pad_rdreq/conv_valid)
interface conv2d_frame_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      start;
  logic                      busy;
  logic                      done;
  logic [DATA_WIDTH*3-1:0]   src_data;
  logic                      src_empty;
  logic                      src_rdreq;
  logic [DATA_WIDTH*3-1:0]   pad_data;
  logic                      pad_empty;
  logic                      pad_rdreq;
  logic                      conv_valid;

  modport master (
    input  start,
    output busy,
    output done,
    input  src_data,
    input  src_empty,
    output src_rdreq,
    output pad_data,
    output pad_empty,
    input  pad_rdreq,
    input  conv_valid
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    output src_data,
    output src_empty,
    input  src_rdreq,
    input  pad_data,
    input  pad_empty,
    output pad_rdreq,
    output conv_valid
  );
endinterface

// File: rtl/conv2d_frame_sequencer.sv
// rtl/conv2d_frame_sequencer.sv - zero-border insertion and layer completion tracking for a conv layer
//
// Turns an unpadded WIDTHxHEIGHT {B,G,R} show-ahead pixel stream into a
// (WIDTH+2)x(HEIGHT+2) show-ahead stream with a one-pixel zero border, then
// counts the filter bank's valid outputs and pulses done once per frame.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   bus.start        begin one frame (only looked at in IDLE)
//   bus.busy         high from the cycle after start until done
//   bus.done         one-cycle completion pulse
//   bus.src_data     upstream pixel {B,G,R}, show-ahead
//   bus.src_empty    upstream FIFO empty
//   bus.src_rdreq    upstream pop
//   bus.pad_data     padded pixel to the filter bank
//   bus.pad_empty    padded stream empty
//   bus.pad_rdreq    filter bank read request
//   bus.conv_valid   filter bank output valid
//   stall_cnt        starvation + backpressure cycles in FEED
//                    (only when CONV_SEQ_STALL_STATS_EN is defined)
module conv2d_frame_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 112,
  parameter int HEIGHT     = 112
) (
  input  logic                      clk,
  input  logic                      rst,
  conv2d_frame_sequencer_if.master  bus
`ifdef CONV_SEQ_STALL_STATS_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int COL_W = $clog2(WIDTH + 2);
  localparam int ROW_W = $clog2(HEIGHT + 2);
  localparam int CNT_W = $clog2(WIDTH * HEIGHT + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH + 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH * HEIGHT);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [CNT_W-1:0]   out_cnt;
  logic               busy_q;
  logic               done_q;

  logic                    in_feed;
  logic                    border;
  logic                    xfer;
  logic                    last_word;
  logic                    cnt_inc;
  logic                    cnt_hit;
  logic [DATA_WIDTH*3-1:0] pad_data_c;
  logic                    pad_empty_c;
  logic                    src_rdreq_c;

  // The padded stream is a pure function of position and the upstream FIFO
  // head, so interior pixels pass through with no added latency and the
  // stream naturally holds while the filter bank is not reading.
  always_comb begin
    in_feed     = (state == FEED);
    border      = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
    pad_data_c  = '0;
    pad_empty_c = 1'b1;
    src_rdreq_c = 1'b0;
    if (in_feed) begin
      if (border) begin
        pad_empty_c = 1'b0;
      end else begin
        pad_data_c  = bus.src_data;
        pad_empty_c = bus.src_empty;
        src_rdreq_c = bus.pad_rdreq & ~bus.src_empty;
      end
    end
    xfer      = ~pad_empty_c & bus.pad_rdreq;
    last_word = in_feed && xfer && (row == ROW_LAST) && (col == COL_LAST);
    cnt_inc   = ((state == FEED) || (state == DRAIN)) && bus.conv_valid && (out_cnt != CNT_FULL);
    // Completion must see a conv_valid arriving in this very cycle.
    cnt_hit   = (out_cnt == CNT_FULL) || (cnt_inc && (out_cnt == CNT_PRE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      out_cnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (cnt_inc) begin
        out_cnt <= out_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= FEED;
            col    <= '0;
            row    <= '0;
            busy_q <= 1'b1;
          end
        end
        FEED: begin
          if (xfer) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
          // Outputs may already be all in; then skip DRAIN entirely.
          if (last_word) begin
            if (cnt_hit) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cnt_hit) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          col     <= '0;
          row     <= '0;
          out_cnt <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CONV_SEQ_STALL_STATS_EN
  // Counts both upstream starvation (reader waiting on an empty stream) and
  // downstream backpressure (word offered but not taken).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && bus.start) begin
      stall_cnt <= '0;
    end else if (in_feed && ((bus.pad_rdreq && pad_empty_c) || (!pad_empty_c && !bus.pad_rdreq))) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pad_data  = pad_data_c;
  assign bus.pad_empty = pad_empty_c;
  assign bus.src_rdreq = src_rdreq_c;

endmodule

// File: tb/tb_conv2d_frame_sequencer.sv
// tb/tb_conv2d_frame_sequencer.sv - randomized self-checking bench for conv2d_frame_sequencer
module tb_conv2d_frame_sequencer;

  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int NW = (W + 2) * (H + 2);
  localparam int NP = W * H;

  logic clk = 1'b0;
  logic rst;

  conv2d_frame_sequencer_if #(.DATA_WIDTH(DW)) bus ();

`ifdef CONV_SEQ_STALL_STATS_EN
  logic [31:0] stall_cnt;
`endif

  conv2d_frame_sequencer #(
    .DATA_WIDTH(DW),
    .WIDTH     (W),
    .HEIGHT    (H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master)
`ifdef CONV_SEQ_STALL_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW*3-1:0] act, input logic [DW*3-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Source FIFO contents and expected padded frame, raster order.
  logic [DW*3-1:0] src_q[$];
  logic [DW*3-1:0] exp_frame [NW];

  function automatic logic [DW*3-1:0] rand_pix();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic bit coin(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.start      = 1'b0;
      bus.conv_valid = coin(50);
      bus.pad_rdreq  = coin(50);
      bus.src_empty  = coin(50);
      bus.src_data   = rand_pix();
      @(negedge clk);
      check("idle_busy", bus.busy, 1'b0);
      check("idle_done", bus.done, 1'b0);
      check("idle_pad_empty", bus.pad_empty, 1'b1);
      check("idle_src_rdreq", bus.src_rdreq, 1'b0);
      check("idle_pad_data", bus.pad_data, '0);
      @(posedge clk);
      #1;
    end
  endtask

  // One frame: start in an idle cycle, then track every cycle against a
  // position-based model of the padded raster and the completion rule.
  task automatic run_frame(input int p_rd, input int p_starve, input int p_cv,
                           input bit cv_late, input int rst_at, input bit burst_en);
    int  idx, cnt, pops, stall, burst_left, r, c;
    bit  exp_busy, exp_done, finished, in_feed, bord, e_empty, e_rdreq, xfer, burst_used;
    int  cyc;

    src_q.delete();
    for (int i = 0; i < NP; i++) src_q.push_back(rand_pix());
    for (int rr = 0; rr < H + 2; rr++)
      for (int cc = 0; cc < W + 2; cc++)
        exp_frame[rr*(W+2)+cc] = (rr == 0 || rr == H + 1 || cc == 0 || cc == W + 1)
                                 ? '0 : src_q[(rr-1)*W + (cc-1)];

    idx = 0; cnt = 0; pops = 0; stall = 0; burst_left = 0; burst_used = 0;
    exp_busy = 0; exp_done = 0; finished = 0; cyc = 0;

    bus.start      = 1'b1;
    bus.conv_valid = 1'b1;
    bus.pad_rdreq  = coin(p_rd);
    bus.src_empty  = 1'b0;
    bus.src_data   = src_q[0];

    while (!finished && cyc < 2000) begin
      cyc++;
      @(negedge clk);
      in_feed = exp_busy && (idx < NW);
      if (in_feed) begin
        r       = idx / (W + 2);
        c       = idx % (W + 2);
        bord    = (r == 0 || r == H + 1 || c == 0 || c == W + 1);
        e_empty = bord ? 1'b0 : bus.src_empty;
        e_rdreq = !bord && bus.pad_rdreq && !bus.src_empty;
      end else begin
        e_empty = 1'b1;
        e_rdreq = 1'b0;
      end
      check("busy", bus.busy, exp_busy);
      check("done", bus.done, exp_done);
      check("pad_empty", bus.pad_empty, e_empty);
      check("src_rdreq", bus.src_rdreq, e_rdreq);
      if (!e_empty) check("pad_data", bus.pad_data, exp_frame[idx]);
      else if (!in_feed) check("pad_data_zero", bus.pad_data, '0);

      if (rst_at >= 0 && exp_busy && idx == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_pad_empty", bus.pad_empty, 1'b1);
        check("rst_src_rdreq", bus.src_rdreq, 1'b0);
        check("rst_done", bus.done, 1'b0);
        @(posedge clk);
        #1;
        check("rst_edge_busy", bus.busy, 1'b0);
        check("rst_edge_pad_empty", bus.pad_empty, 1'b1);
        check("rst_edge_src_rdreq", bus.src_rdreq, 1'b0);
        rst = 1'b0;
        bus.start = 1'b0;
        src_q.delete();
        return;
      end

      xfer = !e_empty && bus.pad_rdreq;
      if (exp_done) begin
        exp_done = 0;
        finished = 1;
      end else if (!exp_busy) begin
        if (bus.start) exp_busy = 1;
      end else begin
        if (in_feed && ((bus.pad_rdreq && e_empty) || (!e_empty && !bus.pad_rdreq))) stall++;
        if (bus.conv_valid && cnt < NP) cnt++;
        if (xfer) idx++;
        if (e_rdreq) pops++;
        if (idx == NW && cnt == NP) begin
          exp_busy = 0;
          exp_done = 1;
        end
      end

      @(posedge clk);
      #1;
      if (e_rdreq && src_q.size() > 0) void'(src_q.pop_front());

      if (burst_en && !burst_used && exp_busy && idx == W + 2 + W + 2 + 3) begin
        burst_left = 5;
        burst_used = 1;
      end
      bus.start     = exp_done ? 1'b1 : (exp_busy ? coin(12) : 1'b0);
      bus.pad_rdreq = coin(p_rd);
      bus.src_empty = (src_q.size() == 0) || (burst_left > 0) || coin(p_starve);
      if (burst_left > 0) burst_left--;
      bus.src_data  = (src_q.size() > 0) ? src_q[0] : rand_pix();
      bus.conv_valid = cv_late ? ((idx >= NW) ? coin(p_cv) : 1'b0) : coin(p_cv);
    end

    check("frame_finished", finished, 1'b1);
    check("transfers", idx, NW);
    check("pops", pops, NP);
    check("src_left", src_q.size(), 0);
`ifdef CONV_SEQ_STALL_STATS_EN
    check("stall_cnt", stall_cnt, stall);
`endif
    bus.start = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.src_data   = '0;
    bus.src_empty  = 1'b1;
    bus.pad_rdreq  = 1'b0;
    bus.conv_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_src_rdreq", bus.src_rdreq, 1'b0);
    check("reset_pad_empty", bus.pad_empty, 1'b1);
    check("reset_pad_data", bus.pad_data, '0);
`ifdef CONV_SEQ_STALL_STATS_EN
    check("reset_stall_cnt", stall_cnt, '0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2);

    run_frame(100, 0, 40, 1, -1, 0);
    idle_cycles(2);
    run_frame(100, 0, 40, 1, -1, 1);
    idle_cycles(2);
    run_frame(50, 0, 30, 0, -1, 0);
    idle_cycles(2);
    run_frame(80, 10, 30, 0, 17, 0);
    idle_cycles(2);
    run_frame(90, 10, 30, 0, -1, 0);
    idle_cycles(2);
    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(30, 100), $urandom_range(0, 40), $urandom_range(10, 60),
                bit'($urandom_range(1)), -1, bit'($urandom_range(1)));
      idle_cycles(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv2d_frame_sequencer.md
Name: conv2d_frame_sequencer

Overview:
Frame-level controller in front of the per-filter featuremap_conv2d blocks of a conv layer. It takes the unpadded RGB pixel FIFO stream, inserts the one-pixel zero border the 3x3 filters expect, and presents a (WIDTH+2)x(HEIGHT+2) show-ahead FIFO-style stream to the filter bank. It counts the bank's valid outputs and reports layer completion. One instance sequences one input frame per start pulse.

Parameters:
DATA_WIDTH, 32, width of one float32 channel word
WIDTH, 112, unpadded frame width in pixels
HEIGHT, 112, unpadded frame height in pixels

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin one frame; sampled only in IDLE
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the frame is complete
src_data  in  DATA_WIDTH*3  upstream pixel {B,G,R}, show-ahead
src_empty  in  1  upstream FIFO empty
src_rdreq  out  1  pop upstream FIFO
pad_data  out  DATA_WIDTH*3  padded stream to the filter bank data_in
pad_empty  out  1  padded stream empty (filter bank uses ~pad_empty as valid)
pad_rdreq  in  1  filter bank rdreq
conv_valid  in  1  valid_out from the filter bank (one filter's valid_out is representative)

Behaviour:
- Reset values: busy=0, done=0, src_rdreq=0, pad_empty=1, pad_data=0. FSM=IDLE, all counters=0.
- Transfer rule: a padded word moves when pad_empty==0 && pad_rdreq==1 in the same cycle.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE: pad_empty=1. When start=1, go to FEED next cycle with col=0 and row=0. busy rises in that same transition.
- FEED: col counts 0..WIDTH+1 and row counts 0..HEIGHT+1. Both advance only on a transfer. col wraps to 0 and row increments at col==WIDTH+1.
- Border position (row==0, row==HEIGHT+1, col==0 or col==WIDTH+1): pad_empty=0, pad_data=0 on all three channels, src_rdreq=0.
- Interior position: pad_data=src_data, pad_empty=src_empty, src_rdreq=pad_rdreq & ~src_empty. This path is combinational and adds zero latency.
- On the transfer at row==HEIGHT+1, col==WIDTH+1, go to DRAIN. pad_empty=1 from the next cycle.
- Output counter out_cnt increments on every conv_valid in FEED or DRAIN, and saturates at WIDTH*HEIGHT.
- DRAIN: when out_cnt reaches WIDTH*HEIGHT (including a conv_valid in the current cycle), go to DONE.
- If out_cnt reaches WIDTH*HEIGHT while still in FEED, stay in FEED until the last padded word, then go straight to DONE.
- DONE: single cycle with done=1 and busy=0. Counters clear. Next state is IDLE.
- start while busy or in DONE is ignored.
- conv_valid in IDLE is ignored and not counted.
- Upstream empty during interior: stall. Counters hold, pad_empty=1, no pops.
- Downstream not reading: hold. Counters, pad_data and src_rdreq are all stable.
- Reset asserted mid-frame: immediate return to IDLE with all outputs at reset values. Partially consumed source data is not restored.
- Counter widths: $clog2(WIDTH+2), $clog2(HEIGHT+2), $clog2(WIDTH*HEIGHT+1).

Optional Feature:
Macro CONV_SEQ_STALL_STATS_EN.
- When defined: adds output stall_cnt (32 bits). It counts cycles in FEED where pad_rdreq=1 and pad_empty=1 (upstream starvation), and also cycles in FEED where pad_empty=0 and pad_rdreq=0 (downstream backpressure).
- stall_cnt clears on the start acceptance, holds its value after done, and resets to 0.
- When undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- WIDTH=4, HEIGHT=3, source holds 12 pixels, pad_rdreq held 1, conv_valid pulsed 12 times after feed -> exactly 30 transfers, in raster order: row 0 all zero, rows 1..3 as 0,p,p,p,p,0, row 4 all zero; 12 src_rdreq pops; done pulses once; busy falls with done.
- Same frame, src_empty forced 1 for 5 cycles at row 2 col 3 -> pad_empty=1 during the gap, no border words skipped, word order unchanged, total 30 transfers.
- pad_rdreq toggled 1/0 every cycle -> pad_data stable while not read, 30 transfers, 12 pops, no duplicate pops.
- start pulsed again during FEED and during DONE -> ignored; exactly one done; out_cnt not reset.
- rst asserted at transfer 17 -> next edge busy=0, pad_empty=1, src_rdreq=0; new start replays from row 0 col 0.
- With CONV_SEQ_STALL_STATS_EN, the first scenario plus 3 cycles of pad_rdreq=0 on border words -> stall_cnt=3.
